// File: rtl/sample_sequencer.sv
// Purpose : buffers sample words in a DEPTH-entry FIFO and releases one word per PERIOD-cycle slot onto Datos.
// Latency : first word 2 edges after enable & !empty is sampled, then exactly one word every PERIOD cycles.
// Backpres: no ready; writes to a full FIFO are dropped (sticky overflow), empty slots flag sticky underrun.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              run (1) / stop (0) the slot schedule
//   wr_en, wr_data      sample word push from the loader
//   err_clr             clears overflow and underrun
//   Datos, sample_stb   registered sample and its one-cycle strobe
//   full, empty, level  registered FIFO occupancy status
//   busy                scheduler not idle
//   overflow, underrun  sticky error flags
module sample_sequencer #(
  parameter int DATA_W = 29,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int PERIOD = 2100000,
  parameter int CNT_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] Datos,
  output logic              sample_stb,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow,
  output logic              underrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STARVED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [ADDR_W:0]  LEVEL_MAX = (ADDR_W + 1)'(DEPTH);

  // Scheduler state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // FIFO state; storage itself carries no reset, pointers define validity
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  // Output registers
  logic [DATA_W-1:0]  datos_q, datos_d;
  logic               stb_q, stb_d;
  logic               ovf_q, ovf_d;
  logic               und_q, und_d;

  // Slot / handshake decode
  logic               pop_slot;
  logic               pop_vld;
  logic               push_vld;
  logic               starve_evt;
  logic               ovf_evt;

  always_comb begin
    pop_slot   = (state_q != ST_IDLE) && (cnt_q == '0);
    pop_vld    = pop_slot && !empty_q;
    starve_evt = pop_slot && empty_q;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
    push_vld   = wr_en && (!full_q || pop_vld);
    ovf_evt    = wr_en && full_q && !pop_vld;
  end

  // FIFO pointer / occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push_vld);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop_vld);
    level_d  = level_q;
    unique case ({push_vld, pop_vld})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LEVEL_MAX);
    empty_d = (level_d == '0);
  end

  // FSM: next-state and slot counter
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (!empty_q)  state_d = ST_RUN;
        ST_RUN:     if (starve_evt) state_d = ST_STARVED;
        ST_STARVED: if (pop_vld)   state_d = ST_RUN;
        default:    state_d = ST_IDLE;
      endcase
    end

    // Counter sits at 0 in IDLE and on the entry cycle into RUN, so the
    // first cycle after the transition is already a pop slot.
    if (state_d == ST_IDLE || state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM: outputs
  always_comb begin
    datos_d = pop_vld ? mem_q[rd_ptr_q] : datos_q;
    stb_d   = pop_vld;
    // New error in the same cycle as err_clr leaves the flag set.
    ovf_d   = ovf_evt    || (ovf_q && !err_clr);
    und_d   = starve_evt || (und_q && !err_clr);
  end

  // FSM / FIFO / output state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      datos_q  <= '0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      datos_q  <= datos_d;
      stb_q    <= stb_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign Datos      = datos_q;
  assign sample_stb = stb_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = ovf_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Purpose : directed + randomized bench for sample_sequencer with a queue-based reference model.
// Latency : model is evaluated once per rising edge, outputs compared 1 time unit later.
// Backpres: none; the bench drives wr_en freely and expects drops / underruns as modelled.
module tb_sample_sequencer;

  localparam int DW    = 29;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PER   = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] Datos;
  logic          sample_stb;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          busy;
  logic          overflow;
  logic          underrun;

  always #5 clk = ~clk;

  sample_sequencer #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .PERIOD(PER), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .err_clr(err_clr), .Datos(Datos), .sample_stb(sample_stb), .full(full),
    .empty(empty), .level(level), .busy(busy), .overflow(overflow), .underrun(underrun)
  );

  // Reference model: queue of stored words, a running flag and the number of
  // cycles elapsed since the schedule started; pop slots are every PER cycles.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_datos;
  bit            m_stb, m_ovf, m_und, m_run;
  int            m_t;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int pre;
    bit slot, pop, und_ev, ovf_ev;
    if (rst) begin
      m_q.delete();
      m_datos = '0;
      m_stb = 0; m_ovf = 0; m_und = 0; m_run = 0; m_t = 0;
    end else begin
      pre    = m_q.size();
      slot   = m_run && (m_t % PER == 0);
      pop    = slot && (pre > 0);
      und_ev = slot && (pre == 0);
      m_stb  = pop;
      if (pop) m_datos = m_q.pop_front();
      ovf_ev = 0;
      if (wr_en) begin
        if (m_q.size() < DEPTH) m_q.push_back(wr_data);
        else ovf_ev = 1;
      end
      m_ovf = ovf_ev || (m_ovf && !err_clr);
      m_und = und_ev || (m_und && !err_clr);
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = (pre > 0); m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic check_all();
    check("datos",    64'(Datos),      64'(m_datos));
    check("stb",      64'(sample_stb), 64'(m_stb));
    check("level",    64'(level),      64'(m_q.size()));
    check("full",     64'(full),       64'(m_q.size() == DEPTH));
    check("empty",    64'(empty),      64'(m_q.size() == 0));
    check("busy",     64'(busy),       64'(m_run));
    check("overflow", 64'(overflow),   64'(m_ovf));
    check("underrun", 64'(underrun),   64'(m_und));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_en = 1'b1;
    wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  logic [DW-1:0] w[$];
  logic [DW-1:0] extra;
  int            stb_seen;

  initial begin
    // Reset
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("rst_datos", 64'(Datos), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));

    // 1: three words, then enable; samples 8 cycles apart, then underrun
    for (int i = 0; i < 3; i++) w.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) push(w[i]);
    enable = 1'b1;
    step();
    step();
    check("t1_first_datos", 64'(Datos), 64'(w[0]));
    check("t1_first_stb",   64'(sample_stb), 64'(1));
    run(8);
    check("t1_second_datos", 64'(Datos), 64'(w[1]));
    run(8);
    check("t1_third_datos", 64'(Datos), 64'(w[2]));
    run(8);
    check("t1_underrun", 64'(underrun), 64'(1));
    check("t1_busy",     64'(busy),     64'(1));

    // 2: recover from starvation
    extra = DW'($urandom);
    push(extra);
    run(7);
    check("t2_datos",    64'(Datos),    64'(extra));
    check("t2_underrun", 64'(underrun), 64'(1));
    clear_errs();
    check("t2_cleared",  64'(underrun), 64'(0));
    enable = 1'b0;
    step();

    // 3: seventeen pushes while stopped
    w.delete();
    for (int i = 0; i < 17; i++) w.push_back(DW'($urandom));
    for (int i = 0; i < 17; i++) push(w[i]);
    check("t3_level",    64'(level),    64'(16));
    check("t3_full",     64'(full),     64'(1));
    check("t3_overflow", 64'(overflow), 64'(1));
    clear_errs();

    // 4: push on the pop-slot cycle of a full FIFO
    enable = 1'b1;
    step();
    extra = DW'($urandom);
    push(extra);
    check("t4_level",    64'(level),    64'(16));
    check("t4_overflow", 64'(overflow), 64'(0));
    check("t4_datos",    64'(Datos),    64'(w[0]));
    run(15 * 8);
    check("t4_last_orig", 64'(Datos), 64'(w[15]));
    run(8);
    check("t4_extra",     64'(Datos), 64'(extra));
    run(10);

    // 5: drop enable mid-slot, re-raise 5 cycles later
    enable = 1'b0;
    step();
    clear_errs();
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back(DW'($urandom));
    for (int i = 0; i < 4; i++) push(w[i]);
    enable = 1'b1;
    run(4);
    enable = 1'b0;
    run(5);
    check("t5_busy",  64'(busy),  64'(0));
    check("t5_datos", 64'(Datos), 64'(w[0]));
    check("t5_level", 64'(level), 64'(3));
    enable = 1'b1;
    step();
    step();
    check("t5_restart", 64'(Datos), 64'(w[1]));
    run(6);

    // 6: reset at cnt=4 with five words queued
    rst = 1'b1;
    step();
    rst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    enable = 1'b1;
    run(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_datos", 64'(Datos), 64'(0));
    check("t6_level", 64'(level), 64'(0));
    check("t6_busy",  64'(busy),  64'(0));
    stb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_stb) stb_seen = stb_seen + 1;
    end
    check("t6_no_stb", 64'(stb_seen), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_data = DW'($urandom);
      enable  = ($urandom_range(0, 31) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;
    err_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
